muldiv_seq: RTL
===============

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and HI/LO width; all behaviour below is stated for WIDTH=32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an operation.
REQ-005 The block SHALL have port op, input, 2 bits: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 The block SHALL have port src_a, input, 32 bits: rs value (multiplicand or dividend).
REQ-007 The block SHALL have port src_b, input, 32 bits: rt value (multiplier or divisor).
REQ-008 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse; hi, lo and div_zero are valid while it is high.
REQ-010 The block SHALL have port hi, output, 32 bits: HI register (upper product or remainder).
REQ-011 The block SHALL have port lo, output, 32 bits: LO register (lower product or quotient).
REQ-012 The block SHALL have port div_zero, output, 1 bit: high together with done when a divide had src_b=0.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, CALC, FIX and DONE; busy SHALL be 1 in CALC and FIX only, and done SHALL be 1 in DONE only.
REQ-014 In IDLE, start=1 at edge E0 SHALL latch op, src_a and src_b, clear a 6-bit iteration counter, and move the FSM to CALC; start SHALL be ignored in every other state.
REQ-015 Latched operands SHALL be used for the whole operation, so input changes while busy=1 have no effect.
REQ-016 For signed ops (MULT, DIV), operands SHALL be converted to 32-bit unsigned magnitudes at latch time, and the sign of each operand SHALL be recorded.
REQ-017 In CALC, each cycle SHALL perform one radix-2 step, so CALC lasts exactly 32 cycles (counter 0..31); the multiply step is shift-add into a 64-bit accumulator, and the divide step is restoring shift-subtract.
REQ-018 In FIX, a signed multiply whose operand signs differ SHALL have its 64-bit product two's-complement negated.
REQ-019 In FIX, a signed divide whose operand signs differ SHALL have its quotient negated, and the remainder SHALL take the sign of the dividend.
REQ-020 In FIX, {hi,lo} SHALL be written with the final result, so hi/lo update at edge E0+33; the FSM then enters DONE, and done is high for the one cycle after E0+33.
REQ-021 DONE SHALL return to IDLE on the next edge; a start held high in DONE is not accepted until IDLE, and back-to-back operations are spaced at least 35 cycles apart.
REQ-022 DIV or DIVU with src_b=0 SHALL skip CALC and FIX: the FSM goes IDLE->DONE at E0, done and div_zero are high in the cycle after E0, and hi/lo are unchanged.
REQ-023 div_zero SHALL be 0 whenever done=0, and 0 for all multiplies.
REQ-024 DIV of 0x80000000 by 0xFFFFFFFF SHALL yield lo=0x80000000 and hi=0x00000000 with no flag.
REQ-025 hi and lo SHALL hold their value between operations and change only in FIX or on reset.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, div_zero=0, hi=0, lo=0, counter=0 and all operand/accumulator registers to 0, independent of clk.
REQ-027 Reset asserted mid-operation (CALC or FIX) SHALL abort it with no partial result visible; after release, the first accepted start behaves as from power-up.

Verification
REQ-028 The bench SHALL check MULT with src_a=0xFFFFFFFD, src_b=5 -> busy for 33 cycles, done one cycle, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-029 The bench SHALL check MULTU with src_a=src_b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-030 The bench SHALL check DIV with src_a=0xFFFFFFF9 (-7), src_b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); and DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-031 The bench SHALL check DIVU with src_a=7, src_b=0, with hi/lo preloaded from a prior op -> done and div_zero high one cycle after start, busy never high, hi/lo unchanged.
REQ-032 The bench SHALL check rst_n pulsed low at CALC cycle 10 of a MULTU -> busy=0, hi=lo=0 immediately, no done pulse; a subsequent DIVU 100/7 gives lo=14, hi=2.
REQ-033 The bench SHALL check start held high continuously, with src_a/src_b changed during busy -> results reflect only the operands latched at acceptance, and the next start is accepted only after DONE->IDLE.

Source files
------------

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_seq
//  Purpose  : Sequential radix-2 MULT/MULTU/DIV/DIVU unit with HI/LO results.
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [5:0] c_last_step = 6'(WIDTH - 1);

    state_t             r_state;
    logic [5:0]         r_cnt;
    logic               r_is_div;
    logic               r_signed;
    logic               r_sign_a;
    logic               r_sign_b;
    logic [WIDTH-1:0]   r_mag_a;
    logic [WIDTH-1:0]   r_mag_b;
    logic [2*WIDTH-1:0] r_acc;

    logic               w_signed;
    logic               w_sign_a;
    logic               w_sign_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH:0]     w_msum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_div_next;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [2*WIDTH-1:0] w_result;

    // op[0]=0 selects the signed variants; operands are reduced to magnitudes up front
    assign w_signed = ~op[0];
    assign w_sign_a = w_signed & src_a[WIDTH-1];
    assign w_sign_b = w_signed & src_b[WIDTH-1];
    assign w_mag_a  = w_sign_a ? -src_a : src_a;
    assign w_mag_b  = w_sign_b ? -src_b : src_b;

    // Multiply: acc = {partial, multiplier}; add multiplicand on LSB then shift right
    assign w_addend   = r_acc[0] ? r_mag_a : '0;
    assign w_msum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
    assign w_mul_next = {w_msum, r_acc[WIDTH-1:1]};

    // Divide: acc = {remainder, quotient}; shift left, trial subtract, restore on borrow
    assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_diff     = w_rem_sh - {1'b0, r_mag_b};
    assign w_div_next = w_diff[WIDTH] ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                      : {w_diff[WIDTH-1:0],   r_acc[WIDTH-2:0], 1'b1};

    assign w_quot     = r_acc[WIDTH-1:0];
    assign w_rem      = r_acc[2*WIDTH-1:WIDTH];
    assign w_quot_fix = (r_signed && (r_sign_a ^ r_sign_b)) ? -w_quot : w_quot;
    assign w_rem_fix  = (r_signed && r_sign_a) ? -w_rem : w_rem;
    assign w_result   = r_is_div ? {w_rem_fix, w_quot_fix}
                                 : ((r_signed && (r_sign_a ^ r_sign_b)) ? -r_acc : r_acc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_signed <= 1'b0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_mag_a  <= '0;
            r_mag_b  <= '0;
            r_acc    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    done     <= 1'b0;
                    div_zero <= 1'b0;
                    if (start) begin
                        r_is_div <= op[1];
                        r_signed <= w_signed;
                        r_sign_a <= w_sign_a;
                        r_sign_b <= w_sign_b;
                        r_mag_a  <= w_mag_a;
                        r_mag_b  <= w_mag_b;
                        r_cnt    <= '0;
                        r_acc    <= op[1] ? {{WIDTH{1'b0}}, w_mag_a}
                                          : {{WIDTH{1'b0}}, w_mag_b};
                        // Divide by zero reports straight away and leaves HI/LO alone
                        if (op[1] && (src_b == '0)) begin
                            r_state  <= DONE;
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                        end else begin
                            r_state <= CALC;
                            busy    <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    r_acc <= r_is_div ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == c_last_step) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    hi      <= w_result[2*WIDTH-1:WIDTH];
                    lo      <= w_result[WIDTH-1:0];
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    r_state <= DONE;
                end
                DONE: begin
                    done     <= 1'b0;
                    div_zero <= 1'b0;
                    r_state  <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
